// File: rtl/mac3_pkg.sv
// Shared types and arithmetic for the mac3 stream engine.
// mac_wide works at MAX_W; callers zero-extend and pick the bits they need.
package mac3_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_W      = 64;

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_t;

  typedef logic [2*MAX_W:0] wide_t;

  function automatic wide_t mac_wide(input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b,
                                     input logic [MAX_W-1:0] c);
    logic [2*MAX_W-1:0] prod;
    prod = (2*MAX_W)'(a) * (2*MAX_W)'(b);
    return wide_t'(prod) + wide_t'(c);
  endfunction

endpackage

// File: rtl/mac3_window.sv
// Three-entry shift register (w0 oldest, w2 newest), shifts on en; async active-low clear.
// Latency 1 cycle from d to w2; no backpressure, every enabled word is taken.
module mac3_window #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] w0,
  output logic [W-1:0] w1,
  output logic [W-1:0] w2
);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      w0 <= '0;
      w1 <= '0;
      w2 <= '0;
    end else if (en) begin
      w0 <= w1;
      w1 <= w2;
      w2 <= d;
    end
  end

endmodule

// File: rtl/mac3_stream_engine.sv
// Sliding-window a*b+c over three consecutive valid words with overflow flag and result counter.
// Registered output, 1 cycle after the third valid word; no backpressure, sink must always accept.
module mac3_stream_engine
  import mac3_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              validi,
  input  logic [DATA_W-1:0] data_in,
  output logic              valido,
  output logic [DATA_W-1:0] data_out,
  output logic              ovf,
  output logic [CNT_W-1:0]  result_cnt
);

  state_t            state_q, state_d;
  logic              fire;
  logic [DATA_W-1:0] w0_unused, w1, w2;
  wide_t             sum;

  mac3_window #(.W(DATA_W)) u_window (
    .clk (clk),
    .rst_(rst_),
    .en  (validi),
    .d   (data_in),
    .w0  (w0_unused),
    .w1  (w1),
    .w2  (w2)
  );

  // Before this edge's shift, w1/w2 hold the two previous valid words.
  assign sum  = mac_wide(MAX_W'(w1), MAX_W'(w2), MAX_W'(data_in));
  assign fire = validi && ((state_q == FILL2) || (state_q == RUN));

  always_comb begin
    state_d = IDLE;
    if (validi) begin
      case (state_q)
        IDLE:    state_d = FILL1;
        FILL1:   state_d = FILL2;
        FILL2:   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      valido     <= 1'b0;
      data_out   <= '0;
      ovf        <= 1'b0;
      result_cnt <= '0;
    end else begin
      state_q <= state_d;
      valido  <= fire;
      if (fire) begin
        data_out   <= sum[DATA_W-1:0];
        ovf        <= |sum[2*MAX_W:DATA_W];
        result_cnt <= result_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/mac3_stream_engine.md
Name: mac3_stream_engine

Overview:
- Streaming arithmetic engine that produces data_out = a*b + c over a sliding window of three consecutive valid input words.
- It is the producing end of the validi/data_in -> valido/data_out interface that the team's property checkers observe.
- It sits between a word source and a result sink, with a registered output and no backpressure.

Parameters:
- DATA_W, 32, width of data_in and data_out.
- CNT_W, 16, width of the result counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_  input  1  asynchronous active-low reset.
- validi  input  1  data_in carries a valid word this cycle.
- data_in  input  DATA_W  input word.
- valido  output  1  data_out holds a fresh result this cycle.
- data_out  output  DATA_W  result a*b+c, truncated to DATA_W.
- ovf  output  1  the untruncated result of the current valido exceeded DATA_W bits; qualified by valido.
- result_cnt  output  CNT_W  number of results produced since reset; wraps.

Behaviour:
- Reset (Already decided): one clock; reset is asynchronous and active-low, on rst_.
  - While rst_=0: valido=0, data_out=0, ovf=0, result_cnt=0, window registers=0, state=IDLE, all immediately and independently of clk.
  - Normal operation starts on the first rising clk edge after rst_ deasserts.
- Window: three registers w0 (oldest), w1, w2 (newest).
  - On every edge with validi=1, the window shifts: w0<=w1, w1<=w2, w2<=data_in.
- Fill state machine (enum IDLE, FILL1, FILL2, RUN), advanced on each clk edge:
  - IDLE: validi=1 -> FILL1; else stay.
  - FILL1: validi=1 -> FILL2; else -> IDLE.
  - FILL2: validi=1 -> RUN; else -> IDLE.
  - RUN: validi=1 -> RUN; else -> IDLE.
- Output timing: if validi was high at edges t-2, t-1 and t, then valido=1 in the cycle after edge t.
  - data_out in that cycle = data_in(t-2) * data_in(t-1) + data_in(t).
  - The result is computed from the shifting window plus data_in, then registered. Latency is 1 cycle from the third valid word.
- valido rule: valido=1 exactly when the previous three edges all sampled validi=1. Any 0 on validi restarts the fill.
  - valido=1 is never allowed with fewer than three consecutive valid words.
- Sustained validi: a new result every cycle (sliding window, overlapping triples).
- Arithmetic:
  - Product is 2*DATA_W bits; the sum is 2*DATA_W+1 bits, unsigned.
  - data_out = low DATA_W bits of the sum.
  - ovf = OR of all bits above DATA_W-1, registered alongside data_out.
- Hold behaviour: when valido=0, data_out and ovf hold their last values. They are cleared only by reset.
- result_cnt increments by 1 on each cycle in which valido is set, and wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation: any partial fill or RUN is discarded. At least three fresh valid words are required after reset before the next valido.
- Window contents are not cleared when validi drops, but stale words never contribute to a result because the fill restarts.

Decomposition:
- Package mac3_pkg:
  - state enum type (IDLE, FILL1, FILL2, RUN).
  - DATA_W and CNT_W default localparams.
  - function computing the wide result and overflow bit.
- One sub-module, mac3_window: the three-entry shift register with enable and asynchronous active-low clear.
- The top level holds the FSM, the arithmetic and the output registers.

Test Plan:
- Basic: rst_ low 2 cycles then high; validi=1 with data_in 2,3,4 then validi=0 -> exactly one valido pulse the cycle after the 4 is sampled; data_out=10, ovf=0, result_cnt=1.
- Sliding window: validi=1 with data_in 2,3,4,5,6 -> valido high for 3 consecutive cycles with data_out 10, 17, 26; result_cnt=3; data_out holds 26 after validi drops.
- Gap: validi pattern 1,1,0,1,1,0,1 with arbitrary data -> valido never asserted; data_out stays 0.
- Overflow: data_in 0x0001_0000, 0x0001_0000, 0x0000_0001 -> data_out=0x0000_0001, ovf=1. Then 1,1,1 -> data_out=2, ovf=0.
- Reset mid-run: during sustained validi, pull rst_ low asynchronously between edges -> valido, data_out and result_cnt are 0 immediately. After release, valido first rises after three new valid words.
- Counter wrap (CNT_W=2): 6 consecutive results -> result_cnt sequence 1,2,3,0,1,2.
